inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; the value SHALL be a power of two and at least 4.
REQ-002 Port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 Port push_valid, input, 2 bits, fetch-side slot valids; bit1 set with bit0 clear SHALL be treated as 2'b00.
REQ-005 Ports push_pc0, push_instr0, push_pc1 and push_instr1, inputs, 32 bits each, PC and instruction word for fetch slots 0 and 1.
REQ-006 Port pop_req, input, 2 bits, decode-side take request; bit1 set with bit0 clear SHALL be treated as 2'b00.
REQ-007 Port stallI, input, 1 bit, hazard-unit push stall; when high, no entry SHALL be written.
REQ-008 Port stallI_de, input, 1 bit, hazard-unit pop stall; when high, no entry SHALL be removed.
REQ-009 Port flush_que, input, 1 bit, hazard-unit flush; all entries SHALL be discarded.
REQ-010 Port out_valid, output, 2 bits, head-entry valids: bit0 set means count ≥ 1, bit1 set means count ≥ 2.
REQ-011 Ports out_pc0, out_instr0, out_pc1 and out_instr1, outputs, 32 bits each, entries at head and head+1.
REQ-012 Port overflowI, output, 1 bit, asserted when fewer than 2 entries are free.
REQ-013 Port count, output, log2(DEPTH)+1 bits, current occupancy.

Function
REQ-014 The queue SHALL be a circular buffer with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a registered count.
REQ-015 Each entry SHALL hold {pc[31:0], instr[31:0]}, and entry order SHALL be program order: slot0 is written before slot1.
REQ-016 Number of pushes requested, npush_req = popcount(legal push_valid) when stallI=0 and flush_que=0; otherwise 0.
REQ-017 Pushes accepted, npush = min(npush_req, DEPTH-count), using count at the start of the cycle; same-cycle pops SHALL NOT create space.
REQ-018 If only one push fits, slot0 SHALL be written and slot1 discarded; a discarded slot SHALL NOT change any state.
REQ-019 Accepted pushes SHALL write mem[tail] (slot0) and mem[tail+1 mod DEPTH] (slot1), and tail SHALL advance by npush.
REQ-020 Number of pops, npop = popcount(legal pop_req & out_valid) when stallI_de=0 and flush_que=0; otherwise 0.
REQ-021 Request bits without a matching out_valid bit SHALL be ignored; head SHALL advance by npop.
REQ-022 Next count SHALL be count + npush - npop; simultaneous push and pop SHALL both take effect in the same cycle.
REQ-023 Flush: when flush_que=1, head, tail and count SHALL all be 0 at the next edge, regardless of push, pop or stall inputs in that cycle; flush has priority over everything except reset.
REQ-024 Output latency: out_valid, out_pc and out_instr SHALL be combinational from registered state only, so a pushed entry first appears on the cycle after it is written (1-cycle latency).
REQ-025 out_pcN and out_instrN SHALL be 0 whenever out_valid[N]=0.
REQ-026 overflowI SHALL equal (count ≥ DEPTH-1) and SHALL be combinational from registered count only, with no path from push_valid or pop_req.
REQ-027 The count value SHALL never exceed DEPTH and never underflow; both conditions SHALL be flagged by simulation assertions.
REQ-028 Wrap-around: writes and reads crossing index DEPTH-1 to 0 SHALL preserve FIFO order.

Reset
REQ-029 While reset is high, head, tail and count SHALL be 0, out_valid SHALL be 2'b00, overflowI SHALL be 0, and all out data SHALL be 0.
REQ-030 Storage array contents need not be reset.
REQ-031 Reset asserted mid-operation SHALL take effect immediately (asynchronously); queued entries are lost and no write occurs on the edge where reset is high.
REQ-032 After reset deasserts, the first accepted push SHALL land at index 0.

Verification
REQ-033 Reset, push {pc 0x100, 0x104} with both bits set -> next cycle count=2, out_valid=2'b11, out_pc0=0x100, out_pc1=0x104.
REQ-034 DEPTH=8, count=7, push 2'b11 with pop 2'b00 -> only slot0 accepted, count=8; overflowI=1 is already high at count=7 and stays high.
REQ-035 count=8, push 2'b11 and pop 2'b11 in the same cycle -> push discarded, count=6, head advances by 2.
REQ-036 count=5, flush_que=1 with push 2'b11, pop 2'b11 and stallI_de=1 -> next cycle count=0, out_valid=2'b00, and out data are 0.
REQ-037 Stream 20 sequential PCs starting 0x0 with random push/pop/stallI/stallI_de -> popped PCs are strictly sequential across multiple wraps and no entry is duplicated.
REQ-038 Assert reset asynchronously between edges with count=4 -> outputs return to reset values before the next edge, and the first post-reset push appears at out_pc0.

Source files
------------

// File: rtl/inst_queue.sv
// Dual-slot instruction queue between fetch and decode: circular buffer that
// accepts up to two entries and releases up to two entries per cycle.
module inst_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               push_valid,
  input  logic [31:0]              push_pc0,
  input  logic [31:0]              push_instr0,
  input  logic [31:0]              push_pc1,
  input  logic [31:0]              push_instr1,
  input  logic [1:0]               pop_req,
  input  logic                     stallI,
  input  logic                     stallI_de,
  input  logic                     flush_que,
  output logic [1:0]               out_valid,
  output logic [31:0]              out_pc0,
  output logic [31:0]              out_instr0,
  output logic [31:0]              out_pc1,
  output logic [31:0]              out_instr1,
  output logic                     overflowI,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];

  logic [1:0]    push_req;
  logic [1:0]    npush;
  logic [1:0]    npop;
  logic [1:0]    pop_mask;
  logic [CW-1:0] free_slots;
  logic [AW-1:0] tail1;
  logic [AW-1:0] head1;
  logic          we0;
  logic          we1;

  // A set bit1 without bit0 is not a legal slot pattern and requests nothing.
  function automatic logic [1:0] legal_cnt(input logic [1:0] v);
    logic [1:0] n;
    case (v)
      2'b01:   n = 2'd1;
      2'b11:   n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  always_comb begin
    push_req   = 2'd0;
    npush      = 2'd0;
    npop       = 2'd0;
    pop_mask   = 2'b00;
    free_slots = CW'(DEPTH) - count_q;
    if (flush_que || stallI) begin
      push_req = 2'd0;
    end else begin
      push_req = legal_cnt(push_valid);
    end
    // Space is judged against the start-of-cycle count; pops do not free it.
    if ({{(CW-2){1'b0}}, push_req} > free_slots) begin
      npush = free_slots[1:0];
    end else begin
      npush = push_req;
    end
    if (pop_req[0]) begin
      pop_mask = pop_req & out_valid;
    end else begin
      pop_mask = 2'b00;
    end
    if (flush_que || stallI_de) begin
      npop = 2'd0;
    end else begin
      npop = {1'b0, pop_mask[0]} + {1'b0, pop_mask[1]};
    end
    tail1 = tail_q + AW'(1);
    we0   = (npush != 2'd0);
    we1   = (npush == 2'd2);
    if (flush_que) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(npop);
      tail_d  = tail_q + AW'(npush);
      count_d = count_q + CW'(npush) - CW'(npop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset, but an edge that sees reset high must not write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (we0) mem_q[tail_q] <= {push_pc0, push_instr0};
      if (we1) mem_q[tail1]  <= {push_pc1, push_instr1};
    end
  end

  always_comb begin
    head1      = head_q + AW'(1);
    out_valid  = {count_q >= CW'(2), count_q != CW'(0)};
    overflowI  = (count_q >= CW'(DEPTH - 1));
    count      = count_q;
    if (out_valid[0]) begin
      {out_pc0, out_instr0} = mem_q[head_q];
    end else begin
      {out_pc0, out_instr0} = 64'd0;
    end
    if (out_valid[1]) begin
      {out_pc1, out_instr1} = mem_q[head1];
    end else begin
      {out_pc1, out_instr1} = 64'd0;
    end
  end

  inst_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .count_q (count_q),
    .npush   (npush),
    .npop    (npop)
  );
endmodule

// Occupancy checks: the count may never pass DEPTH nor drop below zero.
module inst_queue_chk #(
  parameter int DEPTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  input logic [$clog2(DEPTH):0] count_q,
  input logic [1:0]             npush,
  input logic [1:0]             npop
);
  localparam int CW = $clog2(DEPTH) + 1;

  always @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CW'(DEPTH))
        else $error("inst_queue: count above DEPTH");
      assert (CW'(npop) <= count_q)
        else $error("inst_queue: count underflow");
      assert (count_q + CW'(npush) <= CW'(DEPTH))
        else $error("inst_queue: push beyond capacity");
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Randomized bench for inst_queue against a queue-based reference model,
// plus directed corner cases for capacity, flush and asynchronous reset.
module tb_inst_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  push_valid = 2'b00;
  logic [31:0] push_pc0 = 32'd0, push_instr0 = 32'd0;
  logic [31:0] push_pc1 = 32'd0, push_instr1 = 32'd0;
  logic [1:0]  pop_req = 2'b00;
  logic        stallI = 1'b0, stallI_de = 1'b0, flush_que = 1'b0;
  logic [1:0]  out_valid;
  logic [31:0] out_pc0, out_instr0, out_pc1, out_instr1;
  logic        overflowI;
  logic [3:0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] q[$];
  logic [31:0] dut_pop_pc[$];
  int last_npush;
  int last_npop;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid),
    .push_pc0(push_pc0), .push_instr0(push_instr0),
    .push_pc1(push_pc1), .push_instr1(push_instr1),
    .pop_req(pop_req), .stallI(stallI), .stallI_de(stallI_de),
    .flush_que(flush_que), .out_valid(out_valid),
    .out_pc0(out_pc0), .out_instr0(out_instr0),
    .out_pc1(out_pc1), .out_instr1(out_instr1),
    .overflowI(overflowI), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: compare outputs with the model, drive one cycle
  // of inputs, advance the model across the next rising edge.
  task automatic cyc(input logic [1:0] pv, input logic [31:0] p0, input logic [31:0] i0,
                     input logic [31:0] p1, input logic [31:0] i1, input logic [1:0] pr,
                     input logic si, input logic sde, input logic fl);
    int sz, preq, qreq, npu, npo;
    logic [63:0] e0, e1;
    sz = q.size();
    e0 = (sz >= 1) ? q[0] : 64'd0;
    e1 = (sz >= 2) ? q[1] : 64'd0;
    check("count", 64'(count), 64'(sz));
    check("out_valid", 64'(out_valid), (sz >= 2) ? 64'd3 : (sz >= 1) ? 64'd1 : 64'd0);
    check("overflowI", 64'(overflowI), (sz >= DEPTH - 1) ? 64'd1 : 64'd0);
    check("head0", {out_pc0, out_instr0}, e0);
    check("head1", {out_pc1, out_instr1}, e1);
    push_valid = pv; push_pc0 = p0; push_instr0 = i0; push_pc1 = p1; push_instr1 = i1;
    pop_req = pr; stallI = si; stallI_de = sde; flush_que = fl;
    preq = (fl || si) ? 0 : (pv == 2'b11) ? 2 : (pv == 2'b01) ? 1 : 0;
    npu  = (preq > DEPTH - sz) ? DEPTH - sz : preq;
    qreq = (fl || sde) ? 0 : (pr == 2'b11) ? 2 : (pr == 2'b01) ? 1 : 0;
    npo  = (qreq > sz) ? sz : qreq;
    if (npo >= 1) dut_pop_pc.push_back(out_pc0);
    if (npo == 2) dut_pop_pc.push_back(out_pc1);
    if (fl) begin
      q.delete();
    end else begin
      for (int k = 0; k < npo; k++) void'(q.pop_front());
      if (npu >= 1) q.push_back({p0, i0});
      if (npu == 2) q.push_back({p1, i1});
    end
    last_npush = npu;
    last_npop  = npo;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push2(input logic [31:0] pc);
    cyc(2'b11, pc, $urandom, pc + 32'd4, $urandom, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pushed;
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ovf", 64'(overflowI), 64'd0);
    check("rst_data", {out_pc0, out_instr0, out_pc1[0]}, 65'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Two-slot push from reset, visible on the following cycle.
    cyc(2'b11, 32'h100, 32'hAAAA0001, 32'h104, 32'hAAAA0002, 2'b00, 1'b0, 1'b0, 1'b0);
    check("p2_count", 64'(count), 64'd2);
    check("p2_valid", 64'(out_valid), 64'd3);
    check("p2_pc0", 64'(out_pc0), 64'h100);
    check("p2_pc1", 64'(out_pc1), 64'h104);
    cyc(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1);

    // Fill to DEPTH-1, then overfill and pop at capacity.
    for (int k = 0; k < 3; k++) push2(32'h1000 + 32'(k) * 32'h10);
    cyc(2'b01, 32'h1030, $urandom, 32'h1034, $urandom, 2'b00, 1'b0, 1'b0, 1'b0);
    check("c7_count", 64'(count), 64'd7);
    check("c7_ovf", 64'(overflowI), 64'd1);
    push2(32'h1040);
    check("c8_count", 64'(count), 64'd8);
    check("c8_ovf", 64'(overflowI), 64'd1);
    check("c8_tail_pc", 64'(q[7][63:32]), 64'h1040);
    cyc(2'b11, 32'h1050, $urandom, 32'h1054, $urandom, 2'b11, 1'b0, 1'b0, 1'b0);
    check("c6_count", 64'(count), 64'd6);
    check("c6_pc0", 64'(out_pc0), 64'h1010);
    check("c6_pc1", 64'(out_pc1), 64'h1014);
    cyc(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    check("c5_count", 64'(count), 64'd5);

    // Flush overrides simultaneous push, pop and pop stall.
    cyc(2'b11, 32'h2000, $urandom, 32'h2004, $urandom, 2'b11, 1'b0, 1'b1, 1'b1);
    check("fl_count", 64'(count), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_data", {out_pc0, out_instr0}, 64'd0);

    // Randomized traffic with random data, stalls and occasional flush.
    for (int c = 0; c < 300; c++) begin
      cyc(2'($urandom), $urandom, $urandom, $urandom, $urandom, 2'($urandom),
          ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(19) == 0));
    end
    cyc(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1);

    // Sequential PC stream: pops must come out in order across wraps.
    pushed = 0;
    dut_pop_pc.delete();
    for (int c = 0; c < 600 && dut_pop_pc.size() < 20; c++) begin
      logic [1:0] pv;
      pv = 2'($urandom);
      if (pushed >= 20) pv = 2'b00;
      else if (pushed == 19 && pv == 2'b11) pv = 2'b01;
      cyc(pv, 32'(pushed) * 32'd4, $urandom, 32'(pushed) * 32'd4 + 32'd4, $urandom,
          2'($urandom), ($urandom_range(3) == 0), ($urandom_range(3) == 0), 1'b0);
      pushed += last_npush;
    end
    check("stream_len", 64'(dut_pop_pc.size()), 64'd20);
    for (int i = 0; i < 20 && i < dut_pop_pc.size(); i++) begin
      check($sformatf("stream_pc%0d", i), 64'(dut_pop_pc[i]), 64'(i * 4));
    end

    // Asynchronous reset in the middle of a cycle with four entries queued.
    push2(32'h3000);
    push2(32'h3008);
    check("pre_rst_count", 64'(count), 64'd4);
    #2 reset = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ovf", 64'(overflowI), 64'd0);
    check("arst_data", {out_pc0, out_instr0}, 64'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    cyc(2'b01, 32'h500, 32'h5A5A5A5A, 32'h504, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("post_rst_pc0", 64'(out_pc0), 64'h500);
    check("post_rst_count", 64'(count), 64'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
